// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed, XOR-checksummed byte
// stream, packs little-endian 32-bit words, writes them from word 0 upward and
// releases the core from reset only after a verified image is in memory.
module imem_loader #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StChk, StDone, StErr
  } state_e;

  localparam logic [16:0] MaxLen = 17'(IMEM_WORDS);

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  chk_q;
  logic [31:0] word_q;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid & rx_ready;
  assign len_full  = {rx_data, len_q[7:0]};
  // Word index is 16 bits wide so N = IMEM_WORDS never wraps before CHK.
  assign last_word = (word_idx_q == (len_q - 16'd1));

  // Output decode straight from the state register; every output therefore
  // takes its reset value as soon as rst_n falls.
  always_comb begin
    rx_ready   = 1'b0;
    imem_wren  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StChk: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        imem_wren = 1'b1;
        busy      = 1'b1;
      end
      StDone: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = word_idx_q[ADDR_W-1:0];
  assign imem_wdata = word_q;

  // Loader FSM and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      chk_q      <= '0;
      word_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StLenLo;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            chk_q      <= '0;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_q[7:0] <= rx_data;
            state_q    <= StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_q[15:8] <= rx_data;
            if ({1'b0, len_full} > MaxLen) begin
              state_q <= StErr;
            end else if (len_full == 16'd0) begin
              state_q <= StChk;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            word_q[8*byte_idx_q +: 8] <= rx_data;
            chk_q                     <= chk_q ^ rx_data;
            byte_idx_q                <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + 16'd1;
          state_q    <= last_word ? StChk : StData;
        end
        StChk: begin
          if (accept) begin
            state_q <= (rx_data == chk_q) ? StDone : StErr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus hand-written
// sequences for the full-depth image and reset during a load.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_wren;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream [$];
  logic [5:0]  exp_addr [$];
  logic [31:0] exp_data [$];

  imem_loader #(
    .IMEM_WORDS(64),
    .ADDR_W    (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_wren (imem_wren),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Pulse start, then feed up to 'limit' bytes of 'stream' with rx_valid held.
  // stall_at >= 0 drops rx_valid for 5 cycles before that byte, pulsing start.
  task automatic run_load(input string name, input int limit, input int stall_at,
                          input bit check_end, input bit exp_done, input bit exp_err);
    int  i;
    int  cyc;
    int  nw;
    bit  acc;
    bit  stalled;
    i = 0; cyc = 0; nw = 0; stalled = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, " start busy"}, 32'(busy), 32'd1);
    check({name, " start core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({name, " start done/err"}, 32'({done, err}), 32'd0);
    rx_valid = 1'b1;
    rx_data  = stream[0];
    while (i < limit && cyc < 4000) begin
      if (i == stall_at && !stalled) begin
        stalled  = 1'b1;
        rx_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          start = (k == 2);
          @(negedge clk);
          check({name, " stall busy/ready/wren"}, 32'({busy, rx_ready, imem_wren}), 32'b110);
          @(posedge clk); #1;
        end
        start    = 1'b0;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      acc = rx_ready && rx_valid;
      if (imem_wren) begin
        check({name, " rx_ready in write"}, 32'(rx_ready), 32'd0);
        if (nw < exp_addr.size()) begin
          check({name, " write addr"}, 32'(imem_addr), 32'(exp_addr[nw]));
          check({name, " write data"}, imem_wdata, exp_data[nw]);
        end else begin
          check({name, " unexpected write"}, 32'(nw), 32'(exp_addr.size()));
        end
        nw++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        i++;
        if (i < limit) rx_data = stream[i];
        else rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    check({name, " byte budget"}, 32'(cyc < 4000), 32'd1);
    if (check_end) begin
      @(negedge clk);
      check({name, " write count"}, 32'(nw), 32'(exp_addr.size()));
      check({name, " done"}, 32'(done), 32'(exp_done));
      check({name, " err"}, 32'(err), 32'(exp_err));
      check({name, " core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
      check({name, " end busy/ready"}, 32'({busy, rx_ready}), 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b [11];
    int          nb;
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          exp_done;
    bit          exp_err;
    int          stall_at;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"nominal", '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10,
                8'h00, 8'h30}, 11, 2, 32'h00A00513, 32'h00100593, 1'b1, 1'b0, -1};
    vecs[1] = '{"badsum", '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10,
                8'h00, 8'h31}, 11, 2, 32'h00A00513, 32'h00100593, 1'b0, 1'b1, -1};
    vecs[2] = '{"oversize", '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00}, 2, 0, 32'h0, 32'h0, 1'b0, 1'b1, -1};
    vecs[3] = '{"empty", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00}, 3, 0, 32'h0, 32'h0, 1'b1, 1'b0, -1};
    // Reload from DONE, then a stalled copy inside word 1 with start pulsed.
    vecs[4] = '{"stall", '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10,
                8'h00, 8'h30}, 11, 2, 32'h00A00513, 32'h00100593, 1'b1, 1'b0, 7};

    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    check("reset ready/wren/busy", 32'({rx_ready, imem_wren, busy}), 32'd0);
    check("reset done/err/core", 32'({done, err, core_rst_n}), 32'd0);
    check("reset addr", 32'(imem_addr), 32'd0);
    check("reset wdata", imem_wdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      stream.delete(); exp_addr.delete(); exp_data.delete();
      for (int k = 0; k < vecs[v].nb; k++) stream.push_back(vecs[v].b[k]);
      if (vecs[v].nw > 0) begin exp_addr.push_back(6'd0); exp_data.push_back(vecs[v].d0); end
      if (vecs[v].nw > 1) begin exp_addr.push_back(6'd1); exp_data.push_back(vecs[v].d1); end
      run_load(vecs[v].name, vecs[v].nb, vecs[v].stall_at, 1'b1,
               vecs[v].exp_done, vecs[v].exp_err);
    end

    // Full-depth image: N = 64, last write lands on address 63.
    begin
      logic [7:0]  sum;
      logic [31:0] w;
      stream.delete(); exp_addr.delete(); exp_data.delete();
      sum = 8'h00;
      stream.push_back(8'h40); stream.push_back(8'h00);
      for (int n = 0; n < 64; n++) begin
        w = {8'(n), 8'(~n), 8'h5A, 8'(n + 1)};
        exp_addr.push_back(6'(n)); exp_data.push_back(w);
        for (int k = 0; k < 4; k++) begin
          stream.push_back(w[8*k +: 8]);
          sum = sum ^ w[8*k +: 8];
        end
      end
      stream.push_back(sum);
      run_load("full", stream.size(), -1, 1'b1, 1'b1, 1'b0);
    end

    // Reset asserted between edges while assembling word 1.
    stream.delete(); exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < 11; k++) stream.push_back(vecs[0].b[k]);
    exp_addr.push_back(6'd0); exp_data.push_back(32'h00A00513);
    run_load("midreset", 8, -1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("midreset pre busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset async ready/wren/busy", 32'({rx_ready, imem_wren, busy}), 32'd0);
    check("midreset async addr", 32'(imem_addr), 32'd0);
    check("midreset async wdata", imem_wdata, 32'd0);
    check("midreset async core/done/err", 32'({core_rst_n, done, err}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h02;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post-reset idle ready/wren/busy", 32'({rx_ready, imem_wren, busy}), 32'd0);
    end
    rx_valid = 1'b0;
    stream.delete(); exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < 11; k++) stream.push_back(vecs[0].b[k]);
    exp_addr.push_back(6'd0); exp_data.push_back(32'h00A00513);
    exp_addr.push_back(6'd1); exp_data.push_back(32'h00100593);
    run_load("after reset", 11, -1, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader for the single-cycle core, on the write side of instruction memory.
- Accepts a length-prefixed, checksummed byte stream over a valid/ready interface.
- Packs the bytes into little-endian 32-bit instruction words and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until a complete, verified image has been written.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; must be a power of two, at most 65535.
- ADDR_W, 6, word-address width; equals log2(IMEM_WORDS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_wren  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word to write.
- core_rst_n  out  1  active-low reset to the core; 0 until the load succeeds.
- busy  out  1  load in progress.
- done  out  1  image written and checksum matched.
- err  out  1  load failed.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE.
  - rx_ready, imem_wren, busy, done, err = 0.
  - core_rst_n=0.
  - imem_addr, imem_wdata, word count, byte index and checksum = 0.
- A byte is accepted only in a cycle with rx_valid=1 and rx_ready=1. rx_ready is a pure function of state.
- Stream format:
  - Bytes 0-1: word count N, 16-bit little-endian.
  - Next 4*N bytes: instructions, each little-endian (first byte is bits [7:0]).
  - Final byte: XOR of all instruction bytes (0x00 when N=0).
- States:
  - IDLE:
    - rx_ready=0.
    - start → LEN_LO; clear checksum, byte index and word index.
  - LEN_LO:
    - rx_ready=1, busy=1.
    - Accept → latch N[7:0] → LEN_HI.
  - LEN_HI:
    - rx_ready=1, busy=1.
    - Accept → latch N[15:8], then branch:
      - N > IMEM_WORDS → ERR.
      - N = 0 → CHK.
      - Otherwise → DATA.
  - DATA:
    - rx_ready=1, busy=1.
    - Each accept shifts the byte into the assembly register at lane = byte index, XORs it into the checksum, and increments the 2-bit byte index.
    - On the accept with byte index = 3 → WRITE.
  - WRITE:
    - One cycle only; rx_ready=0, busy=1.
    - imem_wren=1, imem_addr=word index, imem_wdata=assembled word.
    - Next edge: word index increments.
    - If the word just written was word N-1 → CHK, else → DATA.
  - CHK:
    - rx_ready=1, busy=1.
    - Accept → byte equals checksum → DONE, otherwise → ERR.
  - DONE:
    - done=1, core_rst_n=1, rx_ready=0.
    - start → LEN_LO; core_rst_n returns to 0 on the same edge.
  - ERR:
    - err=1, core_rst_n=0, rx_ready=0.
    - start → LEN_LO.
- Latency and handshake:
  - The 4th byte of a word accepted at edge t gives imem_wren=1 during the cycle after t.
  - rx_ready is low for that cycle, so a sender holding rx_valid stalls exactly one cycle per word.
- Throughput: 5 cycles per word with a continuously valid stream.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHK; a load in progress is never restarted.
- imem_wren is high only in WRITE. There are never more than N writes, and none in ERR.
- N = IMEM_WORDS is legal: the final write goes to address IMEM_WORDS-1. The word index must not wrap before the CHK transition.
- If rst_n is asserted mid-load: immediate return to IDLE with reset values. Words already written remain in memory; the core stays in reset.
- If rx_valid drops mid-word: the loader waits indefinitely in its current state with no change.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 02 00 13 05 A0 00 93 05 10 00 30 with rx_valid held.
  - Required: writes (addr 0, 0x00A00513) and (addr 1, 0x00100593); rx_ready low in each WRITE cycle; then done=1, core_rst_n=1, err=0.
- Bad checksum:
  - Stimulus: the same stream with final byte 31.
  - Required: both writes occur, then err=1, done=0, core_rst_n=0.
- Oversize image:
  - Stimulus: IMEM_WORDS=64, length bytes 41 00.
  - Required: ERR right after the 2nd byte; no imem_wren; rx_ready=0.
- Empty image and restart:
  - Stimulus: N=0 with checksum 00, then start from DONE and reload the nominal stream.
  - Required: the N=0 load reaches done=1 with no writes; core_rst_n drops to 0 on the restart edge; the nominal result is reproduced.
- Stall and ignored start:
  - Stimulus: rx_valid deasserted for 5 cycles inside word 1, with start pulsed during the stall.
  - Required: no state change, busy stays 1, and the written words are identical to the nominal case.
- Reset mid-load:
  - Stimulus: rst_n asserted low asynchronously during DATA.
  - Required: outputs take reset values immediately, without waiting for a clock edge; no further writes; after release the block is IDLE and ignores bytes until start.
